// File: rtl/cv32e41p_sleep_ctrl_if.sv
// Signal bundle between the SoC-side sleep controller and its surroundings
// (interrupt/debug sources, core handshake, clock gate).
interface cv32e41p_sleep_ctrl_if;
    logic        boot_en_i;
    logic        core_sleep_i;
    logic [31:0] irq_i;
    logic        debug_req_i;
    logic        fetch_enable_o;
    logic        core_clock_en_o;
    logic [31:0] irq_o;
    logic        debug_req_o;
    logic [31:0] sleep_cycles_o;

    modport slave (
        input  boot_en_i, core_sleep_i, irq_i, debug_req_i,
        output fetch_enable_o, core_clock_en_o, irq_o, debug_req_o, sleep_cycles_o
    );

    modport master (
        output boot_en_i, core_sleep_i, irq_i, debug_req_i,
        input  fetch_enable_o, core_clock_en_o, irq_o, debug_req_o, sleep_cycles_o
    );
endinterface

// File: rtl/cv32e41p_sleep_ctrl.sv
// Core sleep/boot sequencer: post-reset fetch_enable pulse, core clock gating and
// irq/debug masking while the core clock is off. CV32E41P_SLEEP_CTRL_STATS_EN adds a gated-cycle counter.
module cv32e41p_sleep_ctrl #(
    parameter int unsigned BOOT_DELAY  = 4,
    parameter int unsigned GATE_DELAY  = 2,
    parameter int unsigned WAKE_SETTLE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cv32e41p_sleep_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        RUN        = 3'd1,
        SLEEP_PEND = 3'd2,
        GATED      = 3'd3,
        WAKE       = 3'd4
    } state_e;

    localparam logic [7:0] BOOT_CNT = 8'(BOOT_DELAY);
    localparam logic [7:0] GATE_CNT = 8'(GATE_DELAY - 1);
    localparam logic [7:0] WAKE_CNT = 8'(WAKE_SETTLE);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       fetch_en_q;
    logic       clk_en_q;
    logic       fwd_en_q;
    logic       wake;

    assign wake = (|bus.irq_i) || bus.debug_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            cnt_q      <= 8'd0;
            fetch_en_q <= 1'b0;
            clk_en_q   <= 1'b1;
            fwd_en_q   <= 1'b0;
        end else begin
            fetch_en_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    fwd_en_q <= 1'b0;
                    if (bus.boot_en_i) begin
                        if (cnt_q == BOOT_CNT) begin
                            state_q    <= RUN;
                            cnt_q      <= 8'd0;
                            fetch_en_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                // Forwarding opens the cycle after the fetch_enable pulse
                // since fwd_en is only raised from inside RUN when coming out of BOOT.
                RUN: begin
                    fwd_en_q <= 1'b1;
                    if (bus.core_sleep_i) begin
                        state_q <= SLEEP_PEND;
                        cnt_q   <= 8'd0;
                    end
                end
                SLEEP_PEND: begin
                    if (!bus.core_sleep_i || wake) begin
                        state_q  <= RUN;
                        cnt_q    <= 8'd0;
                        fwd_en_q <= 1'b1;
                    end else if (cnt_q == GATE_CNT) begin
                        state_q  <= GATED;
                        cnt_q    <= 8'd0;
                        fwd_en_q <= 1'b0;
                        clk_en_q <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 8'd1;
                        fwd_en_q <= 1'b1;
                    end
                end
                GATED: begin
                    fwd_en_q <= 1'b0;
                    if (wake || !bus.core_sleep_i) begin
                        state_q  <= WAKE;
                        cnt_q    <= 8'd0;
                        clk_en_q <= 1'b1;
                    end
                end
                WAKE: begin
                    if (cnt_q == WAKE_CNT) begin
                        state_q  <= RUN;
                        cnt_q    <= 8'd0;
                        fwd_en_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + 8'd1;
                        fwd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= BOOT;
                    cnt_q    <= 8'd0;
                    fwd_en_q <= 1'b0;
                    clk_en_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef CV32E41P_SLEEP_CTRL_STATS_EN
    logic [31:0] sleep_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sleep_cnt_q <= 32'd0;
        end else if (state_q == GATED && sleep_cnt_q != 32'hFFFF_FFFF) begin
            sleep_cnt_q <= sleep_cnt_q + 32'd1;
        end
    end

    assign bus.sleep_cycles_o = sleep_cnt_q;
`else
    assign bus.sleep_cycles_o = 32'd0;
`endif

    assign bus.fetch_enable_o  = fetch_en_q;
    assign bus.core_clock_en_o = clk_en_q;
    assign bus.irq_o           = bus.irq_i & {32{fwd_en_q}};
    assign bus.debug_req_o     = bus.debug_req_i & fwd_en_q;

endmodule

// File: tb/tb_cv32e41p_sleep_ctrl.sv
// Directed bench: stimulus pushes per-cycle expectations into a scoreboard,
// a negedge monitor pops and compares them, a second monitor tracks fetch_enable pulses.
module tb_cv32e41p_sleep_ctrl;

`ifdef CV32E41P_SLEEP_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int S_FE = 0, S_CE = 1, S_IRQ = 2, S_DBG = 3, S_CNT = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];
    int   fe_q[$];

    cv32e41p_sleep_ctrl_if bus ();

    cv32e41p_sleep_ctrl #(
        .BOOT_DELAY (4),
        .GATE_DELAY (2),
        .WAKE_SETTLE(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) if (!rst) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int s);
        case (s)
            S_FE:    return {31'd0, bus.fetch_enable_o};
            S_CE:    return {31'd0, bus.core_clock_en_o};
            S_IRQ:   return bus.irq_o;
            S_DBG:   return {31'd0, bus.debug_req_o};
            default: return bus.sleep_cycles_o;
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cycle-tagged checks
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc >= 0 && sb[i].cyc <= cyc) begin
                checks++;
                if (sb[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s expired: due cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
                end else if (act(sb[i].sig) !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got %h expected %h", sb[i].name, cyc, act(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // fetch_enable pulse monitor
    always @(negedge clk) begin
        if (bus.fetch_enable_o !== 1'b0) begin
            checks++;
            if (fe_q.size() == 0) begin
                failures++;
                $display("FAIL fetch_enable unexpected pulse at cycle %0d value %b", cyc, bus.fetch_enable_o);
            end else begin
                int e;
                e = fe_q.pop_front();
                if (e != cyc) begin
                    failures++;
                    $display("FAIL fetch_enable pulse at cycle %0d expected cycle %0d", cyc, e);
                end
            end
        end
    end

    // asynchronous-reset checks (entries tagged with cycle -1)
    initial begin
        forever begin
            @(posedge rst);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == -1) begin
                    checks++;
                    if (act(sb[i].sig) !== sb[i].val) begin
                        failures++;
                        $display("FAIL %s async: got %h expected %h", sb[i].name, act(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.boot_en_i    = 1'b1;
        bus.core_sleep_i = 1'b0;
        bus.irq_i        = 32'hFFFF_FFFF;
        bus.debug_req_i  = 1'b1;

        // reset values, with irq/debug raised to prove masking
        expect_at(0, S_FE,  32'd0, "rst_fetch_en");
        expect_at(0, S_CE,  32'd1, "rst_clk_en");
        expect_at(0, S_IRQ, 32'd0, "rst_irq_mask");
        expect_at(0, S_DBG, 32'd0, "rst_dbg_mask");
        expect_at(0, S_CNT, 32'd0, "rst_sleep_cnt");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        bus.irq_i       = 32'd0;
        bus.debug_req_i = 1'b0;

        // boot: pulse in cycle 5, forwarding from cycle 6
        fe_q.push_back(5);
        expect_at(2, S_IRQ, 32'd0, "boot_irq_c2");
        expect_at(5, S_IRQ, 32'd0, "boot_irq_c5");
        expect_at(6, S_IRQ, 32'd1, "boot_irq_c6");
        expect_at(5, S_CE,  32'd1, "boot_clk_en");
        at(2);  bus.irq_i = 32'd1;
        at(7);  bus.irq_i = 32'd0;

        // gate at 13, wake seen at 20
        at(10); bus.core_sleep_i = 1'b1;
        expect_at(12, S_CE, 32'd1, "gate_clk_en_c12");
        expect_at(13, S_CE, 32'd0, "gate_clk_en_c13");
        at(20); bus.irq_i = 32'h800;
        expect_at(20, S_CE,  32'd0,     "wake_clk_en_c20");
        expect_at(21, S_CE,  32'd1,     "wake_clk_en_c21");
        expect_at(21, S_IRQ, 32'd0,     "wake_irq_c21");
        expect_at(23, S_IRQ, 32'h800,   "wake_irq_c23");
        at(21); bus.core_sleep_i = 1'b0;
        at(24); bus.irq_i = 32'd0;
        expect_at(25, S_CNT, STATS ? 32'd8 : 32'd0, "stats_after_first_sleep");

        // one-cycle sleep request aborts
        at(30); bus.core_sleep_i = 1'b1;
        expect_at(31, S_CE, 32'd1, "abort1_c31");
        expect_at(32, S_CE, 32'd1, "abort1_c32");
        expect_at(33, S_CE, 32'd1, "abort1_c33");
        at(31); bus.core_sleep_i = 1'b0;

        // debug in SLEEP_PEND returns to RUN; gating resumes after it drops
        at(40); bus.core_sleep_i = 1'b1;
        expect_at(41, S_DBG, 32'd1, "abort2_dbg_fwd_c41");
        expect_at(41, S_CE,  32'd1, "abort2_c41");
        expect_at(42, S_CE,  32'd1, "abort2_c42");
        expect_at(43, S_CE,  32'd1, "abort2_c43");
        expect_at(44, S_CE,  32'd1, "abort2_c44");
        expect_at(45, S_CE,  32'd0, "abort2_gated_c45");
        at(41); bus.debug_req_i = 1'b1;
        at(42); bus.debug_req_i = 1'b0;

        // simultaneous debug rise and sleep fall in GATED
        at(50); bus.debug_req_i = 1'b1; bus.core_sleep_i = 1'b0;
        expect_at(50, S_DBG, 32'd0, "simul_dbg_c50");
        expect_at(51, S_CE,  32'd1, "simul_clk_en_c51");
        expect_at(52, S_DBG, 32'd0, "simul_dbg_c52");
        expect_at(53, S_DBG, 32'd1, "simul_dbg_c53");
        expect_at(53, S_CE,  32'd1, "simul_clk_en_c53");
        at(54); bus.debug_req_i = 1'b0;
        expect_at(54, S_DBG, 32'd0, "simul_dbg_c54");

        // reset while gated
        at(60); bus.core_sleep_i = 1'b1;
        expect_at(62, S_CNT, STATS ? 32'd14 : 32'd0, "stats_total_c62");
        expect_at(62, S_CE,  32'd1, "rgate_c62");
        expect_at(63, S_CE,  32'd0, "rgate_c63");
        expect_at(66, S_CE,  32'd0, "rgate_c66");
        at(66);
        @(negedge clk);
        #1;
        expect_at(-1, S_CE,  32'd1, "async_rst_clk_en");
        expect_at(-1, S_FE,  32'd0, "async_rst_fetch_en");
        expect_at(-1, S_IRQ, 32'd0, "async_rst_irq");
        bus.core_sleep_i = 1'b0;
        bus.irq_i = 32'd4;
        rst = 1'b1;
        fe_q.push_back(71);
        expect_at(68, S_CNT, 32'd0, "rst_cnt_cleared");
        expect_at(68, S_CE,  32'd1, "reboot_clk_en");
        expect_at(71, S_IRQ, 32'd0, "reboot_irq_c71");
        expect_at(72, S_IRQ, 32'd4, "reboot_irq_c72");
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        at(73); bus.irq_i = 32'd0;

        // 100 gated cycles (83..182)
        at(80); bus.core_sleep_i = 1'b1;
        expect_at(82, S_CE, 32'd1, "long_c82");
        expect_at(83, S_CE, 32'd0, "long_c83");
        at(182); bus.irq_i = 32'h10;
        expect_at(182, S_CE,  32'd0,    "long_c182");
        expect_at(183, S_CE,  32'd1,    "long_c183");
        expect_at(185, S_IRQ, 32'h10,   "long_irq_c185");
        expect_at(184, S_CNT, STATS ? 32'd100 : 32'd0, "stats_100");
        expect_at(190, S_CNT, STATS ? 32'd100 : 32'd0, "stats_hold");
        at(183); bus.core_sleep_i = 1'b0;
        at(186); bus.irq_i = 32'd0;

        at(195);
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
        end
        foreach (fe_q[i]) begin
            checks++;
            failures++;
            $display("FAIL fetch_enable pulse missing at cycle %0d got none expected 1", fe_q[i]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
